// File: rtl/can_pkg.sv
// Shared CAN receive-path types and bus level constants.
// Latency: none (declarations only).
// Backpressure: none.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE_WAIT = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2
  } can_state_t;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

endpackage

// File: rtl/can_bit_destuffer_rx_sync_vote.sv
// Synchronises raw rx, keeps a 3-deep history and votes the sampled bit.
// Latency: rx reaches stage[0] after the two synchroniser flops; vote is combinational from stages.
// Backpressure: none, free-running every sampleclk cycle.
module rx_sync_vote
  import can_pkg::*;
#(
  parameter int MAJORITY = 1
) (
  input  logic sampleclk,
  input  logic rst,
  input  logic rx,
  output logic voted
);

  logic       sync_meta;
  logic       sync_q;
  logic [2:0] stage;

  // Two-flop synchroniser followed by the 3-stage history; everything idles recessive.
  always_ff @(posedge sampleclk) begin
    if (rst) begin
      sync_meta <= CAN_RECESSIVE;
      sync_q    <= CAN_RECESSIVE;
      stage     <= {3{CAN_RECESSIVE}};
    end else begin
      sync_meta <= rx;
      sync_q    <= sync_meta;
      stage     <= {stage[1:0], sync_q};
    end
  end

  // Majority of three filters single-cycle glitches; otherwise take the newest stage.
  assign voted = (MAJORITY != 0)
               ? ((stage[0] & stage[1]) | (stage[0] & stage[2]) | (stage[1] & stage[2]))
               : stage[0];

endmodule

// File: rtl/can_bit_destuffer.sv
// CAN bit stage: votes sampled bits, tracks idle/SOF, strips stuff bits, flags stuff errors.
// Latency: outputs registered, one cycle after the qualifying sample_en.
// Backpressure: none; every accepted sample is consumed in the cycle it arrives.
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int STUFF_LEN = 5,
  parameter int IDLE_BITS = 11,
  parameter int MAJORITY  = 1
) (
  input  logic sampleclk,
  input  logic rst,
  input  logic rx,
  input  logic sample_en,
  input  logic lock,
  input  logic destuff_en,
  input  logic frame_done,
  output logic bit_out,
  output logic bit_valid,
  output logic sof,
  output logic in_frame,
  output logic bus_idle,
  output logic stuff_err,
  output logic abort
);

  localparam int RUN_W  = $clog2(STUFF_LEN + 1);
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_BITS);
  localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);

  can_state_t        state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [RUN_W-1:0]  run_len;
  logic              last_pol;
  logic              voted;
  logic              take;
  logic              at_stuff;
  logic              same_pol;

  rx_sync_vote #(
    .MAJORITY (MAJORITY)
  ) u_vote (
    .sampleclk (sampleclk),
    .rst       (rst),
    .rx        (rx),
    .voted     (voted)
  );

  // A sample only counts while the baud clock is locked.
  assign take     = sample_en & lock;
  assign at_stuff = destuff_en & (run_len == RUN_MAX);
  assign same_pol = (voted == last_pol);

  assign in_frame = (state == FRAME);
  assign bus_idle = (state == IDLE);

  // Bus state machine, run/idle counters and registered bit outputs.
  always_ff @(posedge sampleclk) begin
    if (rst) begin
      state     <= IDLE_WAIT;
      idle_cnt  <= '0;
      run_len   <= '0;
      last_pol  <= CAN_RECESSIVE;
      bit_out   <= CAN_RECESSIVE;
      bit_valid <= 1'b0;
      sof       <= 1'b0;
      stuff_err <= 1'b0;
      abort     <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      sof       <= 1'b0;
      stuff_err <= 1'b0;
      abort     <= 1'b0;

      case (state)
        IDLE_WAIT: begin
          if (take) begin
            if (voted == CAN_RECESSIVE) begin
              if (idle_cnt != IDLE_MAX) begin
                idle_cnt <= idle_cnt + IDLE_ONE;
              end
              if (idle_cnt >= IDLE_MAX - IDLE_ONE) begin
                state <= IDLE;
              end
            end else begin
              idle_cnt <= '0;
            end
          end
        end

        IDLE: begin
          if (take && (voted == CAN_DOMINANT)) begin
            state     <= FRAME;
            bit_out   <= CAN_DOMINANT;
            bit_valid <= 1'b1;
            sof       <= 1'b1;
            run_len   <= RUN_ONE;
            last_pol  <= CAN_DOMINANT;
          end
        end

        FRAME: begin
          if (!lock) begin
            // Lost lock: anything sampled now is untrustworthy.
            abort    <= 1'b1;
            state    <= IDLE_WAIT;
            idle_cnt <= '0;
          end else if (frame_done) begin
            // End of frame beats a coincident bit, but a violation is still reported.
            state    <= IDLE_WAIT;
            idle_cnt <= '0;
            if (take && at_stuff && same_pol) begin
              stuff_err <= 1'b1;
            end
          end else if (take) begin
            if (at_stuff) begin
              if (same_pol) begin
                stuff_err <= 1'b1;
                state     <= IDLE_WAIT;
                idle_cnt  <= '0;
              end else begin
                // Expected stuff bit: consume silently and restart the run.
                run_len  <= RUN_ONE;
                last_pol <= voted;
              end
            end else begin
              bit_out   <= voted;
              bit_valid <= 1'b1;
              last_pol  <= voted;
              if (same_pol) begin
                run_len <= (run_len == RUN_MAX) ? RUN_MAX : run_len + RUN_ONE;
              end else begin
                run_len <= RUN_ONE;
              end
            end
          end
        end

        default: begin
          state    <= IDLE_WAIT;
          idle_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer: idle detect, SOF, destuffing, errors, abort, reset, glitch filter.
module tb_can_bit_destuffer;

  logic sampleclk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic sample_en = 1'b0;
  logic lock = 1'b1;
  logic destuff_en = 1'b0;
  logic frame_done = 1'b0;

  logic bit_out, bit_valid, sof, in_frame, bus_idle, stuff_err, abort;
  logic m0_bit_out, m0_bit_valid, m0_sof, m0_in_frame, m0_bus_idle, m0_stuff_err, m0_abort;

  int checks = 0;
  int failures = 0;

  always #5 sampleclk = ~sampleclk;

  can_bit_destuffer #(.STUFF_LEN(5), .IDLE_BITS(11), .MAJORITY(1)) dut (
    .sampleclk (sampleclk), .rst (rst), .rx (rx), .sample_en (sample_en),
    .lock (lock), .destuff_en (destuff_en), .frame_done (frame_done),
    .bit_out (bit_out), .bit_valid (bit_valid), .sof (sof), .in_frame (in_frame),
    .bus_idle (bus_idle), .stuff_err (stuff_err), .abort (abort)
  );

  can_bit_destuffer #(.STUFF_LEN(5), .IDLE_BITS(11), .MAJORITY(0)) dut_m0 (
    .sampleclk (sampleclk), .rst (rst), .rx (rx), .sample_en (sample_en),
    .lock (lock), .destuff_en (destuff_en), .frame_done (frame_done),
    .bit_out (m0_bit_out), .bit_valid (m0_bit_valid), .sof (m0_sof), .in_frame (m0_in_frame),
    .bus_idle (m0_bus_idle), .stuff_err (m0_stuff_err), .abort (m0_abort)
  );

  // Hold a bit on rx long enough to fill the history, then pulse sample_en.
  // Returns on the falling edge where the registered result is visible.
  task automatic send(input logic b, input logic de);
    @(negedge sampleclk);
    rx = b;
    repeat (5) @(negedge sampleclk);
    sample_en  = 1'b1;
    destuff_en = de;
    @(negedge sampleclk);
    sample_en  = 1'b0;
  endtask

  task automatic go_idle();
    repeat (11) send(1'b1, 1'b0);
    checks++;
    if (bus_idle !== 1'b1) begin
      failures++;
      $display("FAIL go_idle bus_idle got=%0b want=1", bus_idle);
    end
  endtask

  task automatic end_frame();
    @(negedge sampleclk);
    frame_done = 1'b1;
    sample_en  = 1'b1;
    @(negedge sampleclk);
    frame_done = 1'b0;
    sample_en  = 1'b0;
    checks++;
    if (bit_valid !== 1'b0 || in_frame !== 1'b0) begin
      failures++;
      $display("FAIL end_frame valid/in_frame got=%0b%0b want=00", bit_valid, in_frame);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge sampleclk);
    checks++;
    if ({bit_out, bit_valid, sof, in_frame, bus_idle, stuff_err, abort} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset outputs got=%b want=1000000",
               {bit_out, bit_valid, sof, in_frame, bus_idle, stuff_err, abort});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_detect();
    repeat (10) send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    checks++;
    if (bus_idle !== 1'b0 || bit_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_10_then_dom bus_idle/valid got=%0b%0b want=00", bus_idle, bit_valid);
    end
    repeat (10) send(1'b1, 1'b0);
    checks++;
    if (bus_idle !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_10 bus_idle got=%0b want=0", bus_idle);
    end
    send(1'b1, 1'b0);
    checks++;
    if (bus_idle !== 1'b1 || bit_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_11 bus_idle/valid got=%0b%0b want=10", bus_idle, bit_valid);
    end
  endtask

  task automatic test_sof_bits();
    logic vals[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(vals[i], 1'b0);
      checks++;
      if (bit_valid !== 1'b1 || bit_out !== vals[i] || sof !== (i == 0) || in_frame !== 1'b1) begin
        failures++;
        $display("FAIL sof_bits[%0d] valid/out/sof/in_frame got=%0b%0b%0b%0b want=1%0b%0b1",
                 i, bit_valid, bit_out, sof, in_frame, vals[i], (i == 0));
      end
      if (i == 0) begin
        @(negedge sampleclk);
        checks++;
        if (bit_valid !== 1'b0 || sof !== 1'b0 || bus_idle !== 1'b0) begin
          failures++;
          $display("FAIL sof_pulse_width valid/sof/bus_idle got=%0b%0b%0b want=000",
                   bit_valid, sof, bus_idle);
        end
      end
    end
    end_frame();
    go_idle();
  endtask

  task automatic test_destuff();
    logic bits[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_v[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int nv = 0;
    for (int i = 0; i < 7; i++) begin
      send(bits[i], 1'b1);
      if (bit_valid === 1'b1) nv++;
      checks++;
      if (bit_valid !== exp_v[i] || stuff_err !== 1'b0 || (exp_v[i] && bit_out !== bits[i])) begin
        failures++;
        $display("FAIL destuff[%0d] valid/out/err got=%0b%0b%0b want=%0b%0b0",
                 i, bit_valid, bit_out, stuff_err, exp_v[i], bits[i]);
      end
    end
    checks++;
    if (nv != 6 || in_frame !== 1'b1) begin
      failures++;
      $display("FAIL destuff_count valid=%0d in_frame=%0b want 6,1", nv, in_frame);
    end
    end_frame();
    go_idle();
  endtask

  task automatic test_stuff_err();
    send(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b1);
      checks++;
      if (bit_valid !== 1'b1 || bit_out !== 1'b1 || stuff_err !== 1'b0) begin
        failures++;
        $display("FAIL stuff_run[%0d] valid/out/err got=%0b%0b%0b want=110",
                 i, bit_valid, bit_out, stuff_err);
      end
    end
    send(1'b1, 1'b1);
    checks++;
    if (stuff_err !== 1'b1 || bit_valid !== 1'b0 || in_frame !== 1'b0 || bus_idle !== 1'b0) begin
      failures++;
      $display("FAIL stuff_err err/valid/in_frame/bus_idle got=%0b%0b%0b%0b want=1000",
               stuff_err, bit_valid, in_frame, bus_idle);
    end
    go_idle();
  endtask

  task automatic test_abort();
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    @(negedge sampleclk);
    rx        = 1'b0;
    lock      = 1'b0;
    sample_en = 1'b1;
    @(negedge sampleclk);
    sample_en = 1'b0;
    checks++;
    if (abort !== 1'b1 || bit_valid !== 1'b0 || in_frame !== 1'b0) begin
      failures++;
      $display("FAIL abort abort/valid/in_frame got=%0b%0b%0b want=100", abort, bit_valid, in_frame);
    end
    @(negedge sampleclk);
    lock = 1'b1;
    checks++;
    if (abort !== 1'b0) begin
      failures++;
      $display("FAIL abort_width abort got=%0b want=0", abort);
    end
    go_idle();
  endtask

  task automatic test_rst_mid_frame();
    send(1'b0, 1'b1);
    @(negedge sampleclk);
    rst       = 1'b1;
    sample_en = 1'b1;
    rx        = 1'b0;
    @(negedge sampleclk);
    sample_en = 1'b0;
    checks++;
    if ({bit_out, bit_valid, sof, in_frame, bus_idle, stuff_err, abort} !== 7'b1000000) begin
      failures++;
      $display("FAIL rst_mid_frame outputs got=%b want=1000000",
               {bit_out, bit_valid, sof, in_frame, bus_idle, stuff_err, abort});
    end
    rst = 1'b0;
    go_idle();
  endtask

  // One-cycle dominant glitch timed so it sits only in stage[0] at the sample.
  task automatic test_glitch();
    @(negedge sampleclk);
    rx = 1'b0;
    @(negedge sampleclk);
    rx = 1'b1;
    repeat (2) @(negedge sampleclk);
    sample_en = 1'b1;
    @(negedge sampleclk);
    sample_en = 1'b0;
    checks++;
    if (sof !== 1'b0 || bit_valid !== 1'b0 || bus_idle !== 1'b1) begin
      failures++;
      $display("FAIL glitch_maj3 sof/valid/bus_idle got=%0b%0b%0b want=001", sof, bit_valid, bus_idle);
    end
    checks++;
    if (m0_sof !== 1'b1 || m0_bit_valid !== 1'b1 || m0_bit_out !== 1'b0) begin
      failures++;
      $display("FAIL glitch_single sof/valid/out got=%0b%0b%0b want=110", m0_sof, m0_bit_valid, m0_bit_out);
    end
  endtask

  initial begin
    test_reset();
    test_idle_detect();
    test_sof_bits();
    test_destuff();
    test_stuff_err();
    test_abort();
    test_rst_mid_frame();
    test_glitch();
    repeat (3) @(negedge sampleclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
